// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receive framer.
// The state encoding is fixed at 3 bits so that waveform and debug tooling can decode it.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  // Width of a counter that counts 0..range-1; never narrower than one bit.
  function automatic int cnt_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_frame_sync_2ff.sv
// Two-flop synchroniser for one asynchronous input. Latency is 2 clocks and there is no backpressure.
// Both flops load RESET_VAL during reset, so an idle-high line does not look like a falling edge when reset is released.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART receive framer: serial line in, one parallel word plus status pulses per frame.
// Pulses appear 1 clock after the stop-bit sampling tick. There is no backpressure; the consumer must take each pulse.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int SW = cnt_width(OVERSAMPLE);
  localparam int BW = cnt_width(DATA_BITS);

  localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END    = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(DATA_BITS - 1);
  localparam logic          PAR_INIT = (PARITY_ODD != 0);

  state_t               state;
  logic [SW-1:0]        scnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_flag;
  logic                 rx_s;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx_in),
    .q     (rx_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      scnt         <= '0;
      bcnt         <= '0;
      shreg        <= '0;
      par_flag     <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;

      if (tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              scnt  <= '0;
            end
          end

          // A low line must still be low half a bit later, otherwise it was a glitch.
          START: begin
            if (scnt == S_MID) begin
              scnt     <= '0;
              bcnt     <= '0;
              par_flag <= 1'b0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              scnt <= scnt + SW'(1);
            end
          end

          DATA: begin
            if (scnt == S_END) begin
              scnt  <= '0;
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              if (bcnt == B_LAST) begin
                bcnt  <= '0;
                state <= (PARITY_EN != 0) ? PARITY : STOP;
              end else begin
                bcnt <= bcnt + BW'(1);
              end
            end else begin
              scnt <= scnt + SW'(1);
            end
          end

          PARITY: begin
            if (scnt == S_END) begin
              scnt     <= '0;
              par_flag <= (rx_s != ((^shreg) ^ PAR_INIT));
              state    <= STOP;
            end else begin
              scnt <= scnt + SW'(1);
            end
          end

          // The word is published even on a bad stop bit so the consumer can inspect it.
          STOP: begin
            if (scnt == S_END) begin
              scnt     <= '0;
              data_out <= shreg;
              if (rx_s) begin
                data_valid   <= !par_flag;
                parity_error <= par_flag;
                state        <= IDLE;
              end else begin
                frame_error  <= 1'b1;
                parity_error <= par_flag;
                state        <= WAIT_HIGH;
              end
            end else begin
              scnt <= scnt + SW'(1);
            end
          end

          // A held-low line (break) must return high before a new start is accepted.
          WAIT_HIGH: begin
            if (rx_s) begin
              state <= IDLE;
            end
          end

          default: begin
            state <= IDLE;
            scnt  <= '0;
            bcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: a frame-level outcome model feeds per-DUT event queues,
// and a per-cycle compare process checks every pulse and the held data word against it.
module tb_uart_rx_frame;

  localparam int BIT_CLK = 64;  // 16 ticks per bit, one tick every 4 clocks

  typedef struct {
    logic [7:0] data;
    bit         dv;
    bit         fe;
    bit         pe;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick  = 1'b0;
  logic       rx_a  = 1'b1;
  logic       rx_b  = 1'b1;
  logic [7:0] data_a, data_b;
  logic       dv_a, fe_a, pe_a, busy_a;
  logic       dv_b, fe_b, pe_b, busy_b;

  int  vectors     = 0;
  int  miscompares = 0;
  bit  checking    = 1'b0;
  int  tick_cnt    = 0;

  ev_t        q_a[$];
  ev_t        q_b[$];
  logic [7:0] model_a = 8'h00;
  logic [7:0] model_b = 8'h00;
  int n_dv_a = 0, n_fe_a = 0, n_pe_a = 0;
  int n_dv_b = 0, n_fe_b = 0, n_pe_b = 0;

  uart_rx_frame dut_a (
    .clock        (clock),
    .reset        (reset),
    .tick         (tick),
    .rx_in        (rx_a),
    .data_out     (data_a),
    .data_valid   (dv_a),
    .frame_error  (fe_a),
    .parity_error (pe_a),
    .busy         (busy_a)
  );

  uart_rx_frame #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .PARITY_EN  (1),
    .PARITY_ODD (0)
  ) dut_b (
    .clock        (clock),
    .reset        (reset),
    .tick         (tick),
    .rx_in        (rx_b),
    .data_out     (data_b),
    .data_valid   (dv_b),
    .frame_error  (fe_b),
    .parity_error (pe_b),
    .busy         (busy_b)
  );

  initial forever #5 clock = ~clock;

  initial forever begin
    @(negedge clock);
    tick     = (tick_cnt == 3);
    tick_cnt = (tick_cnt + 1) % 4;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame outcome from the line rules: even parity, a good stop bit, and nothing else.
  function automatic ev_t predict(input logic [7:0] d, input bit par_en, input bit par_bit, input bit stop);
    ev_t e;
    bit  par_bad;
    par_bad = par_en && (par_bit != (^d));
    e.data  = d;
    e.fe    = !stop;
    e.pe    = par_bad;
    e.dv    = stop && !par_bad;
    return e;
  endfunction

  always @(negedge clock) begin
    if (checking && !reset) begin
      if (dv_a || fe_a || pe_a) begin
        n_dv_a += int'(dv_a);
        n_fe_a += int'(fe_a);
        n_pe_a += int'(pe_a);
        if (q_a.size() == 0) begin
          check("unexpected_pulse_a", 32'({dv_a, fe_a, pe_a}), 0);
        end else begin
          ev_t e;
          e = q_a.pop_front();
          model_a = e.data;
          check("pulses_a", 32'({dv_a, fe_a, pe_a}), 32'({e.dv, e.fe, e.pe}));
        end
      end
      check("data_out_a", 32'(data_a), 32'(model_a));
      check("dv_fe_exclusive_a", 32'(dv_a & fe_a), 0);
    end
  end

  always @(negedge clock) begin
    if (checking && !reset) begin
      if (dv_b || fe_b || pe_b) begin
        n_dv_b += int'(dv_b);
        n_fe_b += int'(fe_b);
        n_pe_b += int'(pe_b);
        if (q_b.size() == 0) begin
          check("unexpected_pulse_b", 32'({dv_b, fe_b, pe_b}), 0);
        end else begin
          ev_t e;
          e = q_b.pop_front();
          model_b = e.data;
          check("pulses_b", 32'({dv_b, fe_b, pe_b}), 32'({e.dv, e.fe, e.pe}));
        end
      end
      check("data_out_b", 32'(data_b), 32'(model_b));
    end
  end

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx_a = v;
    else            rx_b = v;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input bit par_en,
                            input bit par_bit, input bit stop);
    logic [15:0] bits;
    int          n;
    ev_t         e;
    e = predict(d, par_en, par_bit, stop);
    if (which == 0) q_a.push_back(e);
    else            q_b.push_back(e);
    if (par_en) begin
      bits = {5'b0, stop, par_bit, d, 1'b0};
      n    = 11;
    end else begin
      bits = {6'b0, stop, d, 1'b0};
      n    = 10;
    end
    for (int i = 0; i < n; i++) begin
      set_line(which, bits[i]);
      wait_clk(BIT_CLK);
    end
  endtask

  initial begin
    ev_t pin;
    logic [7:0] part;

    // Hand-computed pins for the model itself.
    pin = predict(8'h07, 1'b1, 1'b1, 1'b1);
    check("model_07_par1", 32'({pin.dv, pin.fe, pin.pe}), 32'b100);
    pin = predict(8'h07, 1'b1, 1'b0, 1'b1);
    check("model_07_par0", 32'({pin.dv, pin.fe, pin.pe}), 32'b001);
    pin = predict(8'hA3, 1'b0, 1'b0, 1'b0);
    check("model_A3_stop0", 32'({pin.dv, pin.fe, pin.pe}), 32'b010);

    // Reset state.
    reset = 1'b1;
    wait_clk(4);
    check("reset_data_a", 32'(data_a), 0);
    check("reset_pulses_a", 32'({dv_a, fe_a, pe_a}), 0);
    check("reset_busy_a", 32'(busy_a), 0);
    check("reset_data_b", 32'(data_b), 0);
    check("reset_busy_b", 32'(busy_b), 0);
    reset    = 1'b0;
    checking = 1'b1;
    wait_clk(BIT_CLK);

    // Short low glitch: 5 ticks is under half a bit.
    rx_a = 1'b0;
    wait_clk(5 * 4);
    check("glitch_busy_during", 32'(busy_a), 1);
    rx_a = 1'b1;
    wait_clk(2 * BIT_CLK);
    check("glitch_busy_after", 32'(busy_a), 0);
    check("glitch_data", 32'(data_a), 0);

    // Plain 8N1 frame.
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    wait_clk(BIT_CLK);
    check("f55_data", 32'(data_a), 32'h55);
    check("f55_busy", 32'(busy_a), 0);

    // Bad stop bit, line held low for 3 more bit times.
    send_frame(0, 8'hA3, 1'b0, 1'b0, 1'b0);
    wait_clk(3 * BIT_CLK);
    check("fA3_busy_low_line", 32'(busy_a), 1);
    check("fA3_data", 32'(data_a), 32'hA3);
    rx_a = 1'b1;
    wait_clk(BIT_CLK);
    check("fA3_busy_after", 32'(busy_a), 0);

    // Even parity on the second instance.
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_clk(BIT_CLK);
    check("p07_good_data", 32'(data_b), 32'h07);
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_clk(BIT_CLK);
    check("p07_bad_data", 32'(data_b), 32'h07);
    check("p07_busy", 32'(busy_b), 0);

    // Reset in the middle of data bit 3 of a 0x3C frame.
    part = 8'h3C;
    rx_a = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 3; i++) begin
      rx_a = part[i];
      wait_clk(BIT_CLK);
    end
    rx_a = part[3];
    wait_clk(BIT_CLK / 2);
    check("midframe_busy", 32'(busy_a), 1);
    reset = 1'b1;
    rx_a  = 1'b1;
    @(posedge clock);
    #1;
    reset   = 1'b0;
    model_a = 8'h00;
    model_b = 8'h00;
    @(negedge clock);
    check("midreset_data_a", 32'(data_a), 0);
    check("midreset_pulses_a", 32'({dv_a, fe_a, pe_a}), 0);
    check("midreset_busy_a", 32'(busy_a), 0);
    check("midreset_data_b", 32'(data_b), 0);
    wait_clk(2 * BIT_CLK);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_clk(BIT_CLK);
    check("f3C_data", 32'(data_a), 32'h3C);

    // Back-to-back frames with no idle gap.
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
    wait_clk(BIT_CLK);
    check("b2b_data", 32'(data_a), 32'hFF);
    check("b2b_busy", 32'(busy_a), 0);

    // Totals: 0x55, 0x3C, 0x00, 0xFF good; one framing error; one parity error on b.
    check("pending_a", q_a.size(), 0);
    check("pending_b", q_b.size(), 0);
    check("count_dv_a", n_dv_a, 4);
    check("count_fe_a", n_fe_a, 1);
    check("count_pe_a", n_pe_a, 0);
    check("count_dv_b", n_dv_b, 1);
    check("count_fe_b", n_fe_b, 0);
    check("count_pe_b", n_pe_b, 1);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Oversampling UART receive framer: turns the serial line into parallel bytes.
- Consumes a 1-cycle sample tick at OVERSAMPLE x baud, produced upstream by the baud-rate tick generator.
- Internal sample counters time bit centres; the block outputs one parallel word per valid frame.
- Sits between the pin-side line input and the downstream receive buffer/consumer.

Parameters:
- DATA_BITS, 8: data bits per frame, LSB first; legal 5..9.
- OVERSAMPLE, 16: ticks per bit period; even, >= 8.
- PARITY_EN, 0: 1 = one parity bit follows the data bits.
- PARITY_ODD, 0: 1 = odd parity, 0 = even; ignored when PARITY_EN = 0.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  sample strobe, one clock wide, OVERSAMPLE x baud.
- rx_in  in  1  asynchronous serial line, idle high.
- data_out  out  DATA_BITS  last received word.
- data_valid  out  1  one-clock pulse: good frame in data_out.
- frame_error  out  1  one-clock pulse: stop bit sampled low.
- parity_error  out  1  one-clock pulse: parity mismatch.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (next edge with reset = 1): data_out = 0; all pulse outputs = 0; busy = 0; state = IDLE; counters = 0; synchroniser flops = 1.
- reset wins over every other event, including mid-frame. No partial word is ever flagged.
- Synchroniser: rx_in passes through 2 flops to give rx_s; the FSM uses rx_s only.
- Counters advance only on clocks where tick = 1:
  - sample counter, 0..OVERSAMPLE-1;
  - bit counter, 0..DATA_BITS-1.
- IDLE:
  - tick and rx_s = 0 → START, sample counter = 0.
- START (confirm start bit at mid-bit):
  - On the tick where the sample counter = OVERSAMPLE/2-1, sample rx_s.
  - rx_s = 0 → DATA, sample counter and bit counter cleared.
  - rx_s = 1 → IDLE (glitch rejected, no output pulse).
- DATA:
  - On the tick where the sample counter = OVERSAMPLE-1, shift rx_s into the shift register MSB; the register shifts right, so the word is LSB first.
  - After the DATA_BITS-th bit → PARITY if PARITY_EN, else STOP.
- PARITY:
  - Sample at OVERSAMPLE-1, same timing as a data bit.
  - Expected bit = XOR of data bits, XOR PARITY_ODD.
  - Mismatch latches a pending parity flag; the FSM then goes → STOP.
- STOP:
  - Sample at OVERSAMPLE-1.
  - data_out is loaded from the shift register whatever the stop-bit value.
  - Stop = 1 and no parity flag: data_valid = 1 on the next clock → IDLE.
  - Stop = 1 with parity flag: parity_error = 1 on the next clock, no data_valid → IDLE.
  - Stop = 0: frame_error = 1 on the next clock; parity_error also pulses if flagged → WAIT_HIGH.
- WAIT_HIGH (break/misframe recovery):
  - Stay until a tick with rx_s = 1, then → IDLE.
  - No start detection while in this state.
- Latency: output pulse appears 1 clock after the stop-bit sampling tick.
- Pulse timing: all pulses are exactly one clock wide; data_valid and frame_error are never asserted together.
- Back-to-back frames: a new start bit may begin immediately after the stop-bit centre. IDLE resumes detection on the next tick.
- tick held high continuously is legal; timing then runs per clock.

Decomposition:
- Package uart_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH;
  - default constants DATA_BITS_DEF = 8 and OVERSAMPLE_DEF = 16;
  - a width helper giving clog2 of the counter ranges.
- One sub-module, sync_2ff: 2-flop synchroniser with a reset value parameter (used here with value 1).
- FSM, counters and shift register stay in uart_rx_frame.

Test Plan:
- Frame 0x55, defaults, tick every 4 clocks, correct 8N1 timing → data_out = 0x55, exactly one data_valid pulse, no error pulses, busy low afterwards.
- rx_in low for 5 ticks, then high → FSM returns to IDLE; no pulses; data_out unchanged at 0.
- Frame 0xA3 with stop bit = 0, line held low 3 further bit times → frame_error pulse, data_out = 0xA3, no data_valid, busy high until rx returns high.
- PARITY_EN = 1 (even), data 0x07:
  - parity bit 1 → data_valid;
  - parity bit 0 → parity_error only, data_out = 0x07.
- reset asserted for 1 clock during data bit 3 of a frame → next clock all outputs 0, busy 0. Following frame 0x3C → data_valid with data_out = 0x3C.
- Back-to-back 0x00 then 0xFF, one stop bit, no idle gap → two data_valid pulses carrying 0x00 then 0xFF.
